// File: rtl/pipeline_pkg.sv
// Shared pipeline-control definitions used by the hazard and forwarding units.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_BUBBLE   = 2'd2,
        HZ_ERROR    = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side view of the hazard control unit: hazard sources in, stage enables/flushes out.
interface hazard_control_unit_if;
    import pipeline_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_memread;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  counter_clear;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  exmem_hold;
    logic [1:0]            state;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    // The pipeline datapath drives hazard sources and consumes the controls.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
               ex_branch_taken, mem_req, mem_ready, counter_clear,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold,
               state, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
               ex_branch_taken, mem_req, mem_ready, counter_clear,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold,
               state, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memread,
    output logic                  load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard FSM: memory-wait stalls with timeout, branch flushes, load-use bubbles,
// plus saturating stall/flush performance counters.
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hz
);

    localparam logic [7:0]       WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_t        state_q, state_next;
    logic [7:0]       wait_cnt_q, wait_cnt_next;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use, use_lu;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold;

    load_use_detect u_load_use_detect (
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_uses_rs1 (hz.id_uses_rs1),
        .id_uses_rs2 (hz.id_uses_rs2),
        .ex_rd       (hz.ex_rd),
        .ex_memread  (hz.ex_memread),
        .load_use    (load_use)
    );

    // Mealy outputs and next state; a completing memory access falls straight into the run rules.
    always_comb begin
        state_next    = state_q;
        wait_cnt_next = wait_cnt_q;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_hold    = 1'b0;
        use_lu        = load_use && (state_q != HZ_BUBBLE);

        case (state_q)
            HZ_RUN, HZ_BUBBLE, HZ_MEM_WAIT: begin
                if ((state_q == HZ_MEM_WAIT) && !hz.mem_ready) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    if (wait_cnt_q == WAIT_LIMIT) begin
                        state_next = HZ_ERROR;
                    end else begin
                        wait_cnt_next = wait_cnt_q + 8'd1;
                    end
                end else if ((state_q != HZ_MEM_WAIT) && hz.mem_req && !hz.mem_ready) begin
                    pc_write      = 1'b0;
                    ifid_write    = 1'b0;
                    exmem_hold    = 1'b1;
                    state_next    = HZ_MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end else begin
                    state_next    = HZ_RUN;
                    wait_cnt_next = 8'd0;
                    if (hz.ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (use_lu) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        state_next = HZ_BUBBLE;
                    end
                end
            end
            HZ_ERROR: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                exmem_hold = 1'b1;
            end
            default: state_next = HZ_RUN;
        endcase

        // Reset keeps the front end flushed and frozen until it is released.
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_hold = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HZ_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q    <= state_next;
            wait_cnt_q <= wait_cnt_next;
            if (state_next == HZ_ERROR) begin
                mem_timeout_q <= 1'b1;
            end
            if (hz.counter_clear) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
                    stall_cnt_q <= stall_cnt_q + CNT_ONE;
                end
                if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
                    flush_cnt_q <= flush_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_hold  = exmem_hold;
    assign hz.state       = state_q;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

endmodule
